axil_slave_regfile: RTL

AXI4-Lite slave register file: the responder end of the AXI4-Lite master traffic our block-design testbenches drive. Holds NUM_REGS 32-bit read/write registers at word offsets 0x0, 0x4, 0x8, …, with per-byte write strobes and independent write and read channel FSMs. Register contents are exported flat to user logic. Sits behind the interconnect as the S00_AXI port of our custom IPs.

---
 rtl/axil_slave_regfile.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit registers with byte strobes and independent write/read channels.
// Optional macro AXIL_SLV_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_slave_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [NUM_REGS*32-1:0]          regs_o,
  output logic                            o_dbg_rd_state
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
`ifdef AXIL_SLV_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  // Handshakes: a transfer happens on the rising edge where VALID and READY are both high.
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  logic [31:0]                   r_regs [NUM_REGS];
  logic                          r_live;
  logic                          r_aw_held, r_w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]                   r_wdata;
  logic [STRB_W-1:0]             r_wstrb;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  rd_state_t                     r_rd_state, w_rd_state_nxt;
  logic [31:0]                   r_rdata;
  logic [1:0]                    r_rresp;

  logic                          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_waddr;
  logic [31:0]                   w_wdata;
  logic [STRB_W-1:0]             w_wstrb;
  logic [IDX_W-1:0]              w_wr_idx, w_rd_idx;
  logic                          w_wr_inr, w_rd_inr;
  logic [31:0]                   w_rd_mux;
  logic                          w_unused;

  assign w_unused = ^{AWPROT, ARPROT, ARADDR[1:0], w_waddr[1:0]};

  // r_live keeps every READY low until the first edge after reset release.
  assign AWREADY = r_live && !r_aw_held && !r_bvalid;
  assign WREADY  = r_live && !r_w_held && !r_bvalid;
  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;

  assign w_waddr  = r_aw_held ? r_awaddr : AWADDR;
  assign w_wdata  = r_w_held ? r_wdata : WDATA;
  assign w_wstrb  = r_w_held ? r_wstrb : WSTRB;
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
  assign w_wr_idx = w_waddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_wr_inr = {1'b0, w_wr_idx} < (IDX_W + 1)'(NUM_REGS);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_inr ? 2'b00 : ERR_RESP;
        for (int k = 0; k < NUM_REGS; k++)
          for (int b = 0; b < STRB_W; b++)
            if (w_wr_inr && w_wr_idx == IDX_W'(k) && w_wstrb[b])
              r_regs[k][8*b +: 8] <= w_wdata[8*b +: 8];
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= WDATA;
          r_wstrb  <= WSTRB;
        end
        if (r_bvalid && BREADY) r_bvalid <= 1'b0;
      end
    end
  end

  assign BVALID = r_bvalid;
  assign BRESP  = r_bresp;

  assign w_rd_idx = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rd_inr = {1'b0, w_rd_idx} < (IDX_W + 1)'(NUM_REGS);

  // Reads sample the pre-edge register value, so a same-edge write is not visible.
  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (w_rd_inr && w_rd_idx == IDX_W'(k)) w_rd_mux = r_regs[k];
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    ARREADY        = 1'b0;
    RVALID         = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        ARREADY = r_live;
        if (ARVALID && r_live) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs = ARVALID && ARREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_state <= R_IDLE;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_mux;
        r_rresp <= w_rd_inr ? 2'b00 : ERR_RESP;
      end
    end
  end

  assign RDATA          = r_rdata;
  assign RRESP          = r_rresp;
  assign o_dbg_rd_state = r_rd_state;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[32*k +: 32] = r_regs[k];
  end

endmodule
